// File: rtl/decode_stage_vec_if.sv
// rtl/decode_stage_vec_if.sv - fetch, write-back and execute-side signals of the vector decode stage
interface decode_stage_vec_if #(
  parameter int XLEN   = 32,
  parameter int LANES  = 8,
  parameter int CTRL_W = 10
);
  localparam int VLEN = XLEN * LANES;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              flush_i;
  logic              wb_we;
  logic              wb_vec;
  logic [4:0]        wb_rd;
  logic [VLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   rs1_o;
  logic [VLEN-1:0]   rs2_o;
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   pc_plus4_o;
  logic [XLEN-1:0]   imm_o;
  logic [4:0]        rd_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              vec_o;

  modport slave (
    input  in_valid, output in_ready, input instr_i, pc_i, pc_plus4_i, imm_i, ctrl_i,
    input  flush_i, wb_we, wb_vec, wb_rd, wb_data,
    output out_valid, input out_ready,
    output rs1_o, rs2_o, pc_o, pc_plus4_o, imm_o, rd_o, ctrl_o, vec_o
  );

  modport master (
    output in_valid, input in_ready, output instr_i, pc_i, pc_plus4_i, imm_i, ctrl_i,
    output flush_i, wb_we, wb_vec, wb_rd, wb_data,
    input  out_valid, output out_ready,
    input  rs1_o, rs2_o, pc_o, pc_plus4_o, imm_o, rd_o, ctrl_o, vec_o
  );
endinterface

// File: rtl/decode_stage_vec.sv
// rtl/decode_stage_vec.sv - scalar/vector register read and decode pipeline stage
module decode_stage_vec #(
  parameter int XLEN   = 32,
  parameter int LANES  = 8,
  parameter int CTRL_W = 10
) (
  input logic clk,
  input logic rst,
  decode_stage_vec_if.slave bus
);
  localparam int VLEN = XLEN * LANES;

  logic [XLEN-1:0]   sreg_q [32];
  logic [XLEN-1:0]   sreg_d [32];
  logic [VLEN-1:0]   vreg_q [32];
  logic [VLEN-1:0]   vreg_d [32];

  logic              out_valid_q, out_valid_d;
  logic [VLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]   pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
  logic [4:0]        rd_q, rd_d, rs1_idx_q, rs1_idx_d, rs2_idx_q, rs2_idx_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              vec_q, vec_d, vs_q, vs_d;

  logic              in_vec, in_vs, load;
  logic [4:0]        in_rs1_idx, in_rs2_idx;
  logic [VLEN-1:0]   in_rs1, in_rs2, hold_rs1, hold_rs2;

  function automatic logic [VLEN-1:0] pick(input logic vec, input logic bcast,
                                           input logic [XLEN-1:0] s, input logic [VLEN-1:0] v);
    if (!vec)  return VLEN'(s);
    if (bcast) return {LANES{s}};
    return v;
  endfunction

  // Next-state register files double as the bypass path: reading _d sees this cycle's write-back.
  always_comb begin
    sreg_d = sreg_q;
    vreg_d = vreg_q;
    if (bus.wb_we) begin
      if (bus.wb_vec)              vreg_d[bus.wb_rd] = bus.wb_data;
      else if (bus.wb_rd != 5'd0)  sreg_d[bus.wb_rd] = bus.wb_data[XLEN-1:0];
    end
  end

  assign in_vec     = (bus.instr_i[6:0] == 7'b1010111);
  assign in_vs      = in_vec && (bus.instr_i[14:12] == 3'b100);
  assign in_rs1_idx = bus.instr_i[19:15];
  assign in_rs2_idx = bus.instr_i[24:20];
  assign in_rs1     = pick(in_vec, in_vs, sreg_d[in_rs1_idx], vreg_d[in_rs1_idx]);
  assign in_rs2     = pick(in_vec, 1'b0, sreg_d[in_rs2_idx], vreg_d[in_rs2_idx]);
  // Re-reading the held indices each stalled cycle is equivalent to snooping write-back.
  assign hold_rs1   = pick(vec_q, vs_q, sreg_d[rs1_idx_q], vreg_d[rs1_idx_q]);
  assign hold_rs2   = pick(vec_q, 1'b0, sreg_d[rs2_idx_q], vreg_d[rs2_idx_q]);

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
    vec_d       = vec_q;
    vs_d        = vs_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    if (bus.flush_i) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      rs1_d       = in_rs1;
      rs2_d       = in_rs2;
      pc_d        = bus.pc_i;
      pc4_d       = bus.pc_plus4_i;
      imm_d       = bus.imm_i;
      rd_d        = bus.instr_i[11:7];
      ctrl_d      = bus.ctrl_i;
      vec_d       = in_vec;
      vs_d        = in_vs;
      rs1_idx_d   = in_rs1_idx;
      rs2_idx_d   = in_rs2_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      rs1_d = hold_rs1;
      rs2_d = hold_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        sreg_q[i] <= '0;
        vreg_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
      vec_q       <= 1'b0;
      vs_q        <= 1'b0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        sreg_q[i] <= sreg_d[i];
        vreg_q[i] <= vreg_d[i];
      end
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      vec_q       <= vec_d;
      vs_q        <= vs_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.rs1_o      = rs1_q;
  assign bus.rs2_o      = rs2_q;
  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc4_q;
  assign bus.imm_o      = imm_q;
  assign bus.rd_o       = rd_q;
  assign bus.ctrl_o     = ctrl_q;
  assign bus.vec_o      = vec_q;
endmodule

// File: doc/decode_stage_vec.md
DECODE_STAGE_VEC -- requirements
Module: decode_stage_vec

Interface
REQ-001 SHALL have parameter XLEN, default 32: scalar register, PC and immediate width.
REQ-002 SHALL have parameter LANES, default 8: vector lane count; VLEN = LANES*XLEN (256 by default).
REQ-003 SHALL have parameter CTRL_W, default 10: width of the pre-decoded control bundle.
REQ-004 SHALL have ports in this order:
  clk  in  1  sole clock, all state on rising edge.
  rst  in  1  synchronous, active-high reset.
  in_valid  in  1  fetch stage offers an instruction.
  in_ready  out  1  stage accepts the instruction this cycle.
  instr_i  in  32  instruction word.
  pc_i, pc_plus4_i  in  XLEN  PC and PC+4 of instr_i.
  imm_i  in  XLEN  sign-extended immediate.
  ctrl_i  in  CTRL_W  control bundle from the control unit.
  flush_i  in  1  kill the held instruction and the incoming one.
  wb_we  in  1  write-back enable.
  wb_vec  in  1  write-back target: 1 vector file, 0 scalar file.
  wb_rd  in  5  write-back register index.
  wb_data  in  VLEN  write-back data.
  out_valid  out  1  execute-side payload valid.
  out_ready  in  1  execute stage accepts the payload.
  rs1_o, rs2_o  out  VLEN  operands.
  pc_o, pc_plus4_o, imm_o  out  XLEN  registered copies.
  rd_o  out  5  destination index.
  ctrl_o  out  CTRL_W  registered control bundle.
  vec_o  out  1  instruction uses the vector datapath.

Function
REQ-005 SHALL contain a 32 x XLEN scalar file and a 32 x VLEN vector file; x0 reads 0 and ignores writes; v0 is an ordinary register.
REQ-006 SHALL write on the rising edge when wb_we=1: the scalar file takes wb_data[XLEN-1:0]; the vector file takes all of wb_data.
REQ-007 SHALL decode vec = (instr_i[6:0]==7'b1010111); rs1 = instr_i[19:15]; rs2 = instr_i[24:20]; rd = instr_i[11:7].
REQ-008 SHALL source operands as follows:
  vec=0: both operands from the scalar file, zero-extended to VLEN.
  vec=1 with funct3 = instr_i[14:12] = 3'b100 (vector-scalar mode): rs1 is the scalar value replicated into all LANES lanes; rs2 comes from the vector file.
  vec=1 otherwise: both operands from the vector file.
REQ-009 SHALL bypass reads: if wb_we=1, wb_rd equals the read index, wb_vec matches the file being read, and the index is not scalar x0, the read returns the wb_data value that is being written in the same cycle.
REQ-010 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-011 SHALL load the payload register when in_valid && in_ready && !flush_i; latency is one cycle from acceptance to out_valid=1.
REQ-012 SHALL keep out_valid=1 and all outputs stable while out_valid && !out_ready (stall).
REQ-013 SHALL snoop write-back while stalled: if a held operand's file, index and mode match a write-back, that operand SHALL be updated the same edge, including broadcast of scalar rs1 in vector-scalar mode; x0 is never updated.
REQ-014 SHALL, when out_valid && out_ready && !(in_valid && in_ready), clear out_valid on the next edge.
REQ-015 SHALL give flush_i priority over load and hold: the next edge sets out_valid=0 and the incoming instruction is dropped; register-file writes still occur.
REQ-016 SHALL behave correctly under back-to-back acceptance (out_ready=1 every cycle): one instruction per cycle with no bubble.

Reset
REQ-017 SHALL, on rst=1 at a rising edge, clear out_valid and every output register to 0 and zero both register files; rst has priority over flush_i, load and write-back.
REQ-018 SHALL drop any held instruction when rst is asserted mid-stall; after reset, in_ready=1.

Verification
REQ-019 Write x5=0x0000_00AA; decode add x1,x5,x5 -> rs1_o=rs2_o=0xAA zero-extended, vec_o=0, out_valid=1 one cycle later.
REQ-020 Write v3=256'h{8{32'h1234_5678}}; write x7=0x9; decode OP-V funct3=100, rs1=x7, rs2=v3 -> rs1_o={8{32'h9}}, rs2_o=v3, vec_o=1.
REQ-021 Same-cycle write-back x9=0x55 and decode reading x9 -> rs1_o=0x55; write-back to x0 -> rs1_o reads 0.
REQ-022 Hold out_ready=0 for 3 cycles with a held instruction reading v2; write v2=all-ones in cycle 2 -> rs1_o becomes all-ones, outputs are otherwise unchanged, and in_ready=0 throughout.
REQ-023 Assert flush_i while stalled with in_valid=1 -> out_valid=0 next cycle, the new instruction never appears, and the flush-cycle write-back is still visible afterwards.
REQ-024 Assert rst mid-stall -> out_valid=0 and all outputs 0 next cycle; a read of any previously written register returns 0.
